cbfp_block_norm: RTL

- Parametrised convergent block-floating-point (CBFP) normaliser for the FFT datapath.
- Accepts N complex lanes per beat. Groups BEATS accepted beats into one block.
- Finds the minimum redundant-sign-bit count over the whole block, then streams the block out normalised to OUT_W bits, with one shared index per block.
- Successor to the fixed 16-lane stage-0 CBFP: width, lane count and block depth are parametrised, a runtime bypass mode is added, and ping-pong buffering gives zero-bubble throughput.

---
 rtl/cbfp_block_norm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normaliser: finds the shared shift of a
// BEATS-deep block of N complex lanes and streams it out at OUT_W bits.
module cbfp_block_norm #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 11,
  parameter int N     = 16,
  parameter int BEATS = 2,
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    bypass,
  input  logic signed [IN_W-1:0]  din_i [0:N-1],
  input  logic signed [IN_W-1:0]  din_q [0:N-1],
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  output logic signed [OUT_W-1:0] dout_i [0:N-1],
  output logic signed [OUT_W-1:0] dout_q [0:N-1],
  output logic [IDX_W-1:0]        index_out
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  function automatic logic [IDX_W-1:0] lzs(
    input logic signed [IN_W-1:0] x
  );
    logic [IDX_W-1:0] n;
    logic run;
    n = '0;
    run = 1'b1;
    for (int i = IN_W - 2; i >= 0; i--) begin
      run = run & (x[i] == x[IN_W-1]);
      if (run) n = n + IDX_W'(1);
    end
    return n;
  endfunction

  function automatic logic signed [OUT_W-1:0] norm(
    input logic signed [IN_W-1:0] x,
    input logic [IDX_W-1:0]       m,
    input logic                   byp
  );
    logic signed [2*IN_W-1:0] w;
    w = {{IN_W{x[IN_W-1]}}, x};
    if (!byp) w = w <<< m;
    return w[IN_W-1 -: OUT_W];
  endfunction

  logic signed [IN_W-1:0] buf_i [2][BEATS][N];
  logic signed [IN_W-1:0] buf_q [2][BEATS][N];

  logic [BW-1:0]    wcnt;
  logic             wsel;
  logic [IDX_W-1:0] run_min;
  logic             byp_lat;

  logic [IDX_W-1:0] beat_min;
  logic [IDX_W-1:0] blk_min;
  logic             blk_byp;

  logic             rd_on;
  logic [BW-1:0]    rcnt;
  logic             rsel;
  logic [IDX_W-1:0] rm;
  logic             rbyp;

  always_comb begin
    beat_min = lzs(din_i[0]);
    for (int k = 0; k < N; k++) begin
      if (lzs(din_i[k]) < beat_min) beat_min = lzs(din_i[k]);
      if (lzs(din_q[k]) < beat_min) beat_min = lzs(din_q[k]);
    end
  end

  // First beat of a block reloads the minimum and the mode directly
  assign blk_min = (wcnt == '0 || run_min > beat_min) ? beat_min : run_min;
  assign blk_byp = (wcnt == '0) ? bypass : byp_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      wsel    <= 1'b0;
      run_min <= '0;
      byp_lat <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int j = 0; j < BEATS; j++)
          for (int k = 0; k < N; k++) begin
            buf_i[b][j][k] <= '0;
            buf_q[b][j][k] <= '0;
          end
    end else if (valid_in) begin
      for (int k = 0; k < N; k++) begin
        buf_i[wsel][wcnt][k] <= din_i[k];
        buf_q[wsel][wcnt][k] <= din_q[k];
      end
      run_min <= blk_min;
      byp_lat <= blk_byp;
      if (wcnt == LAST) begin
        wcnt <= '0;
        wsel <= ~wsel;
      end else begin
        wcnt <= wcnt + BW'(1);
      end
    end
  end

  // A completing block always lands exactly as the previous read ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_on <= 1'b0;
      rcnt  <= '0;
      rsel  <= 1'b0;
      rm    <= '0;
      rbyp  <= 1'b0;
    end else if (valid_in && wcnt == LAST) begin
      rd_on <= 1'b1;
      rcnt  <= '0;
      rsel  <= wsel;
      rm    <= blk_min;
      rbyp  <= blk_byp;
    end else if (rd_on) begin
      if (rcnt == LAST) rd_on <= 1'b0;
      else rcnt <= rcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      index_out <= '0;
      for (int k = 0; k < N; k++) begin
        dout_i[k] <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      valid_out <= rd_on;
      first_out <= rd_on && rcnt == '0;
      last_out  <= rd_on && rcnt == LAST;
      index_out <= (rd_on && !rbyp) ? rm : '0;
      for (int k = 0; k < N; k++) begin
        dout_i[k] <= rd_on ? norm(buf_i[rsel][rcnt][k], rm, rbyp) : '0;
        dout_q[k] <= rd_on ? norm(buf_q[rsel][rcnt][k], rm, rbyp) : '0;
      end
    end
  end

endmodule
